// File: rtl/tcpu_pkg.sv
// rtl/tcpu_pkg.sv - shared types and constants for the SRAM window sequencer
package tcpu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, TURN} state_t;
  typedef enum logic {OWN_CPU, OWN_TURBO} owner_t;

  localparam int MEM_AW = 19;
  localparam logic [7:0] BANK_LO = 8'd0;
  localparam logic [7:0] BANK_HI = 8'd1;
endpackage

// File: rtl/sram_window_sequencer_if.sv
// rtl/sram_window_sequencer_if.sv - turbo core memory port (level request, pulse ack)
interface sram_window_sequencer_if;
  logic                        turbo_req;
  logic                        turbo_rw;
  logic [tcpu_pkg::MEM_AW-1:0] turbo_addr;
  logic [7:0]                  turbo_wdata;
  logic                        turbo_ack;
  logic [7:0]                  turbo_rdata;

  modport master (output turbo_req, turbo_rw, turbo_addr, turbo_wdata,
                  input  turbo_ack, turbo_rdata);
  modport slave  (input  turbo_req, turbo_rw, turbo_addr, turbo_wdata,
                  output turbo_ack, turbo_rdata);
endinterface

// File: rtl/sram_window_sequencer_io_edge_capture.sv
// rtl/sram_window_sequencer_io_edge_capture.sv - IO1/IO2 edge detect, C64 request latch, bank register
module io_edge_capture
  import tcpu_pkg::*;
#(
  parameter int BANK_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io1,
  input  logic              io2,
  input  logic              rw,
  input  logic [7:0]        addr,
  input  logic [7:0]        wdata,
  input  logic              take,
  output logic              req_valid,
  output logic              req_rw,
  output logic [MEM_AW-1:0] req_addr,
  output logic [7:0]        req_wdata,
  output logic [BANK_W-1:0] bank
);
  logic              io1_q, io2_q;
  logic              io1_rise, io2_rise;
  logic              pend;
  logic              lat_rw;
  logic [MEM_AW-1:0] lat_addr;
  logic [7:0]        lat_wdata;

  assign io1_rise = io1 & ~io1_q;
  assign io2_rise = io2 & ~io2_q;

  // A fresh edge bypasses the latch so an idle sequencer can start on the same clock;
  // it also supersedes any stale pending request.
  assign req_valid = pend | io1_rise;
  assign req_rw    = io1_rise ? rw : lat_rw;
  assign req_addr  = io1_rise ? {bank, addr} : lat_addr;
  assign req_wdata = io1_rise ? wdata : lat_wdata;

  always_ff @(posedge clk) begin
    io1_q <= io1;
    io2_q <= io2;
    if (rst) begin
      pend      <= 1'b0;
      lat_rw    <= 1'b1;
      lat_addr  <= '0;
      lat_wdata <= '0;
      bank      <= '0;
    end else begin
      if (io1_rise) begin
        lat_rw    <= rw;
        lat_addr  <= {bank, addr};
        lat_wdata <= wdata;
      end
      if (take)
        pend <= 1'b0;
      else if (io1_rise)
        pend <= 1'b1;
      if (io2_rise && !rw) begin
        if (addr == BANK_LO)
          bank[7:0] <= wdata;
        else if (addr == BANK_HI)
          bank[BANK_W-1:8] <= wdata[BANK_W-9:0];
      end
    end
  end
endmodule

// File: rtl/sram_window_sequencer.sv
// rtl/sram_window_sequencer.sv - time-sliced SRAM arbiter between the C64 IO1 window and the turbo core
module sram_window_sequencer
  import tcpu_pkg::*;
#(
  parameter int ACC_CYCLES = 3,
  parameter int BANK_W     = 11
) (
  input  logic                    clock_mult,
  input  logic                    reset_cpu,
  input  logic                    cpu_io1,
  input  logic                    cpu_io2,
  input  logic                    cpu_rw,
  input  logic [7:0]              cpu_addr,
  input  logic [7:0]              cpu_wdata,
  output logic [7:0]              cpu_rdata,
  sram_window_sequencer_if.slave  turbo,
  output logic [BANK_W-1:0]       bank,
  output logic [MEM_AW-1:0]       address_mem,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  output logic                    mem_drive,
  output logic                    _ce_ram,
  output logic                    _we_mem
);
  localparam int KW = $clog2(ACC_CYCLES);
  localparam logic [KW-1:0] K_LAST = KW'(ACC_CYCLES - 1);

  state_t            state;
  owner_t            owner;
  logic [KW-1:0]     k;
  logic [KW-1:0]     k_next;
  logic              wr;
  logic              take;
  logic              req_valid, req_rw;
  logic [MEM_AW-1:0] req_addr;
  logic [7:0]        req_wdata;
  logic              nxt_rw;
  logic [MEM_AW-1:0] nxt_addr;
  logic [7:0]        nxt_wdata;

  io_edge_capture #(.BANK_W(BANK_W)) u_cap (
    .clk       (clock_mult),
    .rst       (reset_cpu),
    .io1       (cpu_io1),
    .io2       (cpu_io2),
    .rw        (cpu_rw),
    .addr      (cpu_addr),
    .wdata     (cpu_wdata),
    .take      (take),
    .req_valid (req_valid),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .bank      (bank)
  );

  // C64 always beats the turbo core when both are waiting in IDLE.
  assign take      = (state == IDLE) && req_valid;
  assign nxt_rw    = req_valid ? req_rw    : turbo.turbo_rw;
  assign nxt_addr  = req_valid ? req_addr  : turbo.turbo_addr;
  assign nxt_wdata = req_valid ? req_wdata : turbo.turbo_wdata;
  assign k_next    = k + 1'b1;

  always_ff @(posedge clock_mult) begin
    if (reset_cpu) begin
      state             <= IDLE;
      owner             <= OWN_CPU;
      k                 <= '0;
      wr                <= 1'b0;
      _ce_ram           <= 1'b1;
      _we_mem           <= 1'b1;
      mem_drive         <= 1'b0;
      address_mem       <= '0;
      mem_wdata         <= '0;
      cpu_rdata         <= '0;
      turbo.turbo_rdata <= '0;
      turbo.turbo_ack   <= 1'b0;
    end else begin
      turbo.turbo_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid || turbo.turbo_req) begin
            state       <= ACCESS;
            owner       <= req_valid ? OWN_CPU : OWN_TURBO;
            k           <= '0;
            wr          <= ~nxt_rw;
            address_mem <= nxt_addr;
            mem_wdata   <= nxt_wdata;
            mem_drive   <= ~nxt_rw;
            _ce_ram     <= 1'b0;
            _we_mem     <= 1'b1;
          end
        end
        ACCESS: begin
          if (k == K_LAST) begin
            state     <= TURN;
            _ce_ram   <= 1'b1;
            _we_mem   <= 1'b1;
            mem_drive <= 1'b0;
            if (!wr) begin
              if (owner == OWN_CPU)
                cpu_rdata <= mem_rdata;
              else
                turbo.turbo_rdata <= mem_rdata;
            end
            if (owner == OWN_TURBO)
              turbo.turbo_ack <= 1'b1;
          end else begin
            k <= k_next;
            // Strobe sits strictly inside the access so address/data have setup and hold.
            _we_mem <= ~(wr && (k_next != K_LAST));
          end
        end
        TURN:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_window_sequencer.sv
// tb/tb_sram_window_sequencer.sv - self-checking bench with SRAM model and memory/bank reference
module tb_sram_window_sequencer;
  localparam int ACC = 3;
  localparam int BW  = 11;

  typedef struct {
    logic [18:0] addr;
    logic        wr;
    logic [7:0]  wdata;
    int          len;
    int          we_len;
    logic        stable;
  } acc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_io1 = 1'b0, cpu_io2 = 1'b0, cpu_rw = 1'b1;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic [7:0] cpu_rdata;
  logic [BW-1:0] bank;
  logic [18:0] address_mem;
  logic [7:0] mem_wdata, mem_rdata;
  logic mem_drive, _ce_ram, _we_mem;

  sram_window_sequencer_if tif ();

  sram_window_sequencer #(.ACC_CYCLES(ACC), .BANK_W(BW)) dut (
    .clock_mult  (clk),
    .reset_cpu   (rst),
    .cpu_io1     (cpu_io1),
    .cpu_io2     (cpu_io2),
    .cpu_rw      (cpu_rw),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .turbo       (tif),
    .bank        (bank),
    .address_mem (address_mem),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_drive   (mem_drive),
    ._ce_ram     (_ce_ram),
    ._we_mem     (_we_mem)
  );

  always #5 clk = ~clk;

  logic [7:0] sram [0:(1<<19)-1];
  assign mem_rdata = sram[address_mem];
  always @(posedge clk)
    if (!_ce_ram && !_we_mem && mem_drive) sram[address_mem] <= mem_wdata;

  int checks = 0, failures = 0;
  logic [7:0] ref_mem [int];
  logic [BW-1:0] ref_bank = '0;

  acc_t accs[$];
  logic in_acc = 1'b0;
  logic [18:0] a_addr;
  logic a_wr, a_ok;
  logic [7:0] a_wd;
  int a_len, a_we;
  int ack_cnt = 0;

  always @(negedge clk) begin
    if (tif.turbo_ack === 1'b1) ack_cnt <= ack_cnt + 1;
    if (_ce_ram === 1'b0) begin
      if (!in_acc) begin
        in_acc <= 1'b1; a_addr <= address_mem; a_wr <= mem_drive; a_wd <= mem_wdata;
        a_len <= 1; a_we <= int'(!_we_mem); a_ok <= 1'b1;
      end else begin
        a_len <= a_len + 1;
        a_we  <= a_we + int'(!_we_mem);
        if (address_mem !== a_addr || mem_drive !== a_wr || mem_wdata !== a_wd) a_ok <= 1'b0;
      end
    end else if (in_acc) begin
      in_acc <= 1'b0;
      accs.push_back(acc_t'{a_addr, a_wr, a_wd, a_len, a_we, a_ok});
    end
  end

  task automatic io1_pulse(input logic rw, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_rw = rw; cpu_addr = a; cpu_wdata = d; cpu_io1 = 1'b1;
    repeat (3) @(negedge clk);
    cpu_io1 = 1'b0;
  endtask

  task automatic io2_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_rw = 1'b0; cpu_addr = a; cpu_wdata = d; cpu_io2 = 1'b1;
    @(negedge clk);
    cpu_io2 = 1'b0; cpu_rw = 1'b1;
    if (a == 8'd0) ref_bank[7:0] = d;
    else if (a == 8'd1) ref_bank[BW-1:8] = d[BW-9:0];
  endtask

  task automatic set_bank(input logic [BW-1:0] b);
    logic [7:0] hi;
    hi = 8'($urandom);
    hi[BW-9:0] = b[BW-1:8];
    io2_write(8'd0, b[7:0]);
    io2_write(8'd1, hi);
  endtask

  task automatic wait_rec(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (accs.size() > 0) got = 1'b1;
    end
    checks++;
    if (!got) begin failures++; $display("FAIL rec_timeout: no SRAM access seen within 40 clocks"); end
  endtask

  task automatic turbo_op(input logic rw, input logic [18:0] a, input logic [7:0] d,
                          output int lat, output bit got);
    @(negedge clk);
    tif.turbo_req = 1'b1; tif.turbo_rw = rw; tif.turbo_addr = a; tif.turbo_wdata = d;
    got = 1'b0; lat = 0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (tif.turbo_ack === 1'b1) got = 1'b1;
    end
    tif.turbo_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({_ce_ram, _we_mem, mem_drive} !== 3'b110) begin
      failures++; $display("FAIL reset_pins: ce/we/drive=%b expected 110", {_ce_ram, _we_mem, mem_drive});
    end
    checks++;
    if (address_mem !== 19'h0 || mem_wdata !== 8'h0) begin
      failures++; $display("FAIL reset_bus: addr=%h wdata=%h expected 0/0", address_mem, mem_wdata);
    end
    checks++;
    if (cpu_rdata !== 8'h0 || tif.turbo_rdata !== 8'h0 || tif.turbo_ack !== 1'b0 || bank !== '0) begin
      failures++;
      $display("FAIL reset_regs: cpu_rdata=%h turbo_rdata=%h ack=%b bank=%h expected all 0",
               cpu_rdata, tif.turbo_rdata, tif.turbo_ack, bank);
    end
    rst = 1'b0;
    ref_bank = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cpu_write_read();
    bit got;
    acc_t r;
    accs.delete();
    io1_pulse(1'b0, 8'h12, 8'hA5);
    ref_mem[32'h12] = 8'hA5;
    wait_rec(got);
    if (got) begin
      r = accs.pop_front();
      checks++;
      if (r.addr !== 19'h00012 || r.wr !== 1'b1 || r.wdata !== 8'hA5) begin
        failures++; $display("FAIL c64_write_addr: addr=%h wr=%b wd=%h expected 00012/1/a5", r.addr, r.wr, r.wdata);
      end
      checks++;
      if (r.len != ACC || r.we_len != ACC - 2 || r.stable !== 1'b1) begin
        failures++; $display("FAIL c64_write_timing: len=%0d we_len=%0d stable=%b expected %0d/%0d/1",
                             r.len, r.we_len, r.stable, ACC, ACC - 2);
      end
    end
    io1_pulse(1'b1, 8'h12, 8'h00);
    wait_rec(got);
    if (got) begin
      r = accs.pop_front();
      checks++;
      if (cpu_rdata !== ref_mem[32'h12] || r.wr !== 1'b0 || r.we_len != 0) begin
        failures++; $display("FAIL c64_read: rdata=%h wr=%b we_len=%0d expected %h/0/0",
                             cpu_rdata, r.wr, r.we_len, ref_mem[32'h12]);
      end
    end
  endtask

  task automatic test_bank();
    bit got;
    acc_t r;
    accs.delete();
    io2_write(8'd0, 8'h34);
    io2_write(8'd1, 8'h05);
    @(negedge clk);
    checks++;
    if (bank !== ref_bank || bank !== 11'h534) begin
      failures++; $display("FAIL bank_write: bank=%h expected 534", bank);
    end
    @(negedge clk);
    cpu_rw = 1'b1; cpu_addr = 8'd0; cpu_wdata = 8'hEE; cpu_io2 = 1'b1;
    @(negedge clk);
    cpu_io2 = 1'b0;
    io2_write(8'd7, 8'h99);
    repeat (3) @(negedge clk);
    checks++;
    if (bank !== ref_bank || accs.size() != 0) begin
      failures++; $display("FAIL bank_ignore: bank=%h accesses=%0d expected %h/0", bank, accs.size(), ref_bank);
    end
    io1_pulse(1'b1, 8'hFF, 8'h00);
    wait_rec(got);
    if (got) begin
      r = accs.pop_front();
      checks++;
      if (r.addr !== 19'h534FF) begin
        failures++; $display("FAIL bank_window: addr=%h expected 534ff", r.addr);
      end
    end
  endtask

  task automatic test_priority();
    int n;
    logic [18:0] ca;
    ca = {ref_bank, 8'h30};
    accs.delete();
    @(negedge clk);
    cpu_rw = 1'b0; cpu_addr = 8'h30; cpu_wdata = 8'h11; cpu_io1 = 1'b1;
    tif.turbo_req = 1'b1; tif.turbo_rw = 1'b0; tif.turbo_addr = 19'h7ABCD; tif.turbo_wdata = 8'h22;
    n = 0;
    while (n < 40 && tif.turbo_ack !== 1'b1) begin
      @(negedge clk);
      n++;
      if (n == 3) cpu_io1 = 1'b0;
    end
    tif.turbo_req = 1'b0;
    ref_mem[int'(ca)] = 8'h11;
    ref_mem[32'h7ABCD] = 8'h22;
    repeat (2) @(negedge clk);
    checks++;
    if (n != 2 * (ACC + 1) + 1) begin
      failures++; $display("FAIL prio_latency: ack after %0d clocks expected %0d", n, 2 * (ACC + 1) + 1);
    end
    checks++;
    if (accs.size() != 2 || accs[0].addr !== ca || accs[1].addr !== 19'h7ABCD) begin
      failures++; $display("FAIL prio_order: accesses=%0d first=%h second=%h expected 2/%h/7abcd",
                           accs.size(), accs.size() > 0 ? accs[0].addr : 19'h0,
                           accs.size() > 1 ? accs[1].addr : 19'h0, ca);
    end
  endtask

  task automatic test_io1_during_turbo();
    int n, lat;
    bit got, acked;
    logic [18:0] ca;
    ca = {ref_bank, 8'h21};
    turbo_op(1'b0, ca, 8'h3C, lat, got);
    ref_mem[int'(ca)] = 8'h3C;
    repeat (2) @(negedge clk);
    accs.delete();
    @(negedge clk);
    tif.turbo_req = 1'b1; tif.turbo_rw = 1'b1; tif.turbo_addr = 19'h00012;
    @(negedge clk);
    cpu_rw = 1'b1; cpu_addr = 8'h21; cpu_io1 = 1'b1;
    n = 0; acked = 1'b0;
    while (n < 30 && accs.size() < 2) begin
      @(negedge clk);
      n++;
      if (n == 3) cpu_io1 = 1'b0;
      if (tif.turbo_ack === 1'b1) begin
        acked = 1'b1;
        tif.turbo_req = 1'b0;
        checks++;
        if (tif.turbo_rdata !== ref_mem[32'h12]) begin
          failures++; $display("FAIL mid_turbo_rdata: %h expected %h", tif.turbo_rdata, ref_mem[32'h12]);
        end
      end
    end
    tif.turbo_req = 1'b0;
    checks++;
    if (!acked || n > 2 * (ACC + 1) + 1) begin
      failures++; $display("FAIL mid_latency: acked=%b c64 done after %0d clocks expected 1/<=%0d",
                           acked, n, 2 * (ACC + 1) + 1);
    end
    checks++;
    if (accs.size() != 2 || accs[0].addr !== 19'h00012 || accs[1].addr !== ca || cpu_rdata !== 8'h3C) begin
      failures++; $display("FAIL mid_order: accesses=%0d cpu_rdata=%h expected 2 (00012 then %h) / 3c",
                           accs.size(), cpu_rdata, ca);
    end
  endtask

  task automatic test_io1_hold();
    accs.delete();
    @(negedge clk);
    cpu_rw = 1'b1; cpu_addr = 8'h12; cpu_io1 = 1'b1;
    repeat (20) @(negedge clk);
    cpu_io1 = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (accs.size() != 1) begin
      failures++; $display("FAIL io1_hold: %0d accesses expected 1", accs.size());
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int low_cnt, base;
    io2_write(8'd0, 8'h77);
    accs.delete();
    base = ack_cnt;
    @(negedge clk);
    cpu_rw = 1'b0; cpu_addr = 8'h40; cpu_wdata = 8'h5A; cpu_io1 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (_we_mem === 1'b0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL rst_mid_strobe: write strobe never seen"); end
    ref_mem[int'({ref_bank, 8'h40})] = 8'h5A;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ref_bank = '0;
    checks++;
    if ({_ce_ram, _we_mem, mem_drive} !== 3'b110 || bank !== '0 || tif.turbo_ack !== 1'b0) begin
      failures++; $display("FAIL rst_mid_pins: ce/we/drive=%b bank=%h ack=%b expected 110/0/0",
                           {_ce_ram, _we_mem, mem_drive}, bank, tif.turbo_ack);
    end
    cpu_io1 = 1'b0;
    low_cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (_ce_ram !== 1'b1) low_cnt++;
    end
    checks++;
    if (low_cnt != 0 || ack_cnt != base) begin
      failures++; $display("FAIL rst_mid_quiet: ce low %0d clocks, acks %0d expected 0/0", low_cnt, ack_cnt - base);
    end
  endtask

  task automatic test_random();
    logic [18:0] wl[$];
    logic [18:0] a;
    logic [7:0] d;
    int kind, lat;
    bit got;
    acc_t r;
    for (int i = 0; i < 40; i++) begin
      kind = (wl.size() == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      d = 8'($urandom);
      accs.delete();
      case (kind)
        0: begin
          if ($urandom_range(0, 1) == 1) set_bank(BW'($urandom));
          a = {ref_bank, 8'($urandom)};
          io1_pulse(1'b0, a[7:0], d);
          ref_mem[int'(a)] = d;
          wl.push_back(a);
          wait_rec(got);
          if (got) begin
            r = accs.pop_front();
            checks++;
            if (r.addr !== a || r.wr !== 1'b1 || r.wdata !== d) begin
              failures++; $display("FAIL rnd_c64_wr[%0d]: addr=%h wd=%h expected %h/%h", i, r.addr, r.wdata, a, d);
            end
          end
        end
        1: begin
          a = 19'($urandom);
          turbo_op(1'b0, a, d, lat, got);
          ref_mem[int'(a)] = d;
          wl.push_back(a);
          checks++;
          if (!got || lat != ACC + 1) begin
            failures++; $display("FAIL rnd_turbo_wr[%0d]: ack=%b latency=%0d expected 1/%0d", i, got, lat, ACC + 1);
          end
        end
        2: begin
          a = wl[$urandom_range(0, wl.size() - 1)];
          set_bank(a[18:8]);
          io1_pulse(1'b1, a[7:0], 8'h00);
          wait_rec(got);
          if (got) begin
            r = accs.pop_front();
            checks++;
            if (r.addr !== a || cpu_rdata !== ref_mem[int'(a)]) begin
              failures++; $display("FAIL rnd_c64_rd[%0d]: addr=%h rdata=%h expected %h/%h",
                                   i, r.addr, cpu_rdata, a, ref_mem[int'(a)]);
            end
          end
        end
        default: begin
          a = wl[$urandom_range(0, wl.size() - 1)];
          turbo_op(1'b1, a, 8'h00, lat, got);
          checks++;
          if (!got || lat != ACC + 1 || tif.turbo_rdata !== ref_mem[int'(a)]) begin
            failures++; $display("FAIL rnd_turbo_rd[%0d]: ack=%b latency=%0d rdata=%h expected 1/%0d/%h",
                                 i, got, lat, tif.turbo_rdata, ACC + 1, ref_mem[int'(a)]);
          end
        end
      endcase
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    tif.turbo_req = 1'b0; tif.turbo_rw = 1'b1; tif.turbo_addr = '0; tif.turbo_wdata = '0;
    test_reset();
    test_cpu_write_read();
    test_bank();
    test_priority();
    test_io1_during_turbo();
    test_io1_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sram_window_sequencer.md
Name: sram_window_sequencer

Overview:
- Sequences every cycle of the cartridge 512 KB SRAM and shares it between two requesters: the C64 bus, through the IO1 page window, and the turbo core's memory port.
- Runs on clock_mult, far faster than phi2, and time-slices the SRAM so the C64 side always meets its phi2 deadline.
- Owns the IO2 bank register that extends the 256-byte IO1 window to 19 address bits.
- Drives the SRAM control pins; the top-level data-bus muxing uses mem_drive.

Parameters:
- ACC_CYCLES, 3: clocks per SRAM access; minimum 3 (setup, strobe, hold).
- BANK_W, 11: bank register width; BANK_W + 8 = 19 SRAM address bits.

Ports:
- clock_mult  in  1  system clock; all logic on its rising edge.
- reset_cpu  in  1  synchronous, active-high reset.
- cpu_io1  in  1  IO1 select, active-high, already synchronised to clock_mult.
- cpu_io2  in  1  IO2 select, active-high, already synchronised.
- cpu_rw  in  1  C64 R/W (1 = read), synchronised.
- cpu_addr  in  8  C64 A[7:0].
- cpu_wdata  in  8  C64 write data.
- cpu_rdata  out  8  last C64 read byte; held until the next C64 read completes.
- turbo_req  in  1  turbo access request; level, held until ack.
- turbo_rw  in  1  1 = read.
- turbo_addr  in  19  turbo SRAM address.
- turbo_wdata  in  8  turbo write data.
- turbo_ack  out  1  one-clock pulse when the access completes.
- turbo_rdata  out  8  read data, valid with turbo_ack and held afterwards.
- bank  out  BANK_W  current IO1 bank.
- address_mem  out  19  SRAM address.
- mem_wdata  out  8  SRAM write data.
- mem_rdata  in  8  SRAM read data.
- mem_drive  out  1  1 = FPGA drives data_mem.
- _ce_ram  out  1  SRAM chip enable, active-low.
- _we_mem  out  1  SRAM write enable, active-low.

Behaviour:
Reset values:
- _ce_ram=1, _we_mem=1, mem_drive=0, address_mem=0, mem_wdata=0.
- cpu_rdata=0, turbo_rdata=0, turbo_ack=0, bank=0.
- cpu_pend=0, state=IDLE.
- Reset mid-access aborts the access with no ack; the next clock shows all reset values.

C64 requests:
- A rising edge of cpu_io1 (registered previous value) sets cpu_pend and latches cpu_rw, cpu_addr and cpu_wdata.
- The address is formed as {bank, cpu_addr}.
- One access per edge. Holding IO1 high gives no repeat.

Bank register:
- A rising edge of cpu_io2 with cpu_rw=0 writes the register with no SRAM access.
- cpu_addr[0]=0 writes bank[7:0] ← cpu_wdata.
- cpu_addr[0]=1 writes bank[BANK_W-1:8] ← cpu_wdata[BANK_W-9:0].
- IO2 reads and IO2 offsets 2..255 are ignored.
- The new bank applies to IO1 edges detected from the next clock onward.

FSM states: IDLE, ACCESS, TURN.
- IDLE:
  - cpu_pend → ACCESS (C64 owner), clearing cpu_pend.
  - Otherwise turbo_req → ACCESS (turbo owner).
  - The C64 side always wins a simultaneous request.
- ACCESS: counter k runs 0..ACC_CYCLES-1.
  - _ce_ram=0 for the whole state.
  - address_mem and mem_wdata are stable for the whole state.
  - For writes, mem_drive=1 for the whole state and _we_mem=0 only for k=1..ACC_CYCLES-2.
  - For reads, mem_rdata is captured on the clock edge ending k=ACC_CYCLES-1, into cpu_rdata or turbo_rdata by owner.
  - A turbo owner gets turbo_ack=1 in the first TURN cycle.
- ACCESS → TURN unconditionally.
- TURN: one clock with _ce_ram=1 and mem_drive=0, then → IDLE.
- An IO1 edge arriving during ACCESS or TURN sets cpu_pend and is served next.

Latency and capacity:
- Turbo latency is ACC_CYCLES+1 clocks from acceptance to ack.
- Worst-case C64 latency is 2·(ACC_CYCLES+1)+1 clocks. The integrator guarantees this is shorter than half a phi2 cycle.
- A second IO1 edge while cpu_pend is already set is a protocol error; the latched request is overwritten with the newer one.
- Turbo may be starved only by back-to-back C64 edges, which phi2 spacing precludes.
- turbo_req dropped before ack: an already-started access completes and acks; otherwise nothing happens.
- All address arithmetic is plain concatenation; there is no increment and no wrap logic.

Decomposition:
- Shared package tcpu_pkg holds:
  - the FSM state enum (IDLE, ACCESS, TURN);
  - the owner enum (OWN_CPU, OWN_TURBO);
  - MEM_AW=19;
  - bank register offsets BANK_LO=0 and BANK_HI=1.
- One natural sub-module, io_edge_capture: the IO1/IO2 edge detectors plus the C64 request latch and bank register. The FSM and SRAM pin drive stay in the top.

Test Plan:
- IO1 write, bank=0, cpu_addr=8'h12, wdata=8'hA5: address_mem=19'h00012, mem_drive=1 for 3 clocks, _we_mem low exactly 1 clock. A following IO1 read of 8'h12 gives cpu_rdata=8'hA5.
- IO2 writes of 8'h34 @0 and 8'h05 @1: bank=11'h534. The next IO1 read of 8'hFF gives address_mem=19'h534FF.
- turbo_req with IO1 edge on the same clock: the C64 access runs first. Turbo ACCESS starts after TURN, and turbo_ack rises 2·(ACC_CYCLES+1)+1 clocks after request (9 at default).
- IO1 edge during a turbo ACCESS: the turbo access completes and acks, then the C64 access starts immediately after TURN+IDLE. Total C64 latency ≤ 9 clocks.
- reset_cpu asserted at k=1 of a write: the next clock shows _ce_ram=1, _we_mem=1, mem_drive=0, bank=0, with no turbo_ack and no pending access.
- IO1 held high for 20 clocks: exactly one SRAM access occurs.
